uart_tx_cfg: RTL

Parametrised UART transmitter, the successor to the fixed 8-bit/115200 transmitter.
- Serialises one word per Tx_Start into a frame: start bit, DATA_BITS data bits LSB-first, optional even/odd parity, then 1 or 2 stop bits.
- Latches the word at accept, so the upstream source may change Data_to_send during transmission.
- Sits between the system-side producer (CPU/FIFO) and the serial pin; it is the transmit half of the UART module.

---
 rtl/uart_tx_cfg_if.sv | 28 ++
 rtl/uart_tx_cfg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg_if.sv
// Producer-side bundle for uart_tx_cfg: word/request in, serial line and status out.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Data_to_send;
  logic                 Tx_Start;
  logic                 Tx;
  logic                 Tx_Busy;
  logic                 Tx_Done;

  // Producer (CPU/FIFO) side.
  modport master (
    output Data_to_send,
    output Tx_Start,
    input  Tx,
    input  Tx_Busy,
    input  Tx_Done
  );

  // Transmitter side.
  modport slave (
    input  Data_to_send,
    input  Tx_Start,
    output Tx,
    output Tx_Busy,
    output Tx_Done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits. Word is latched at accept.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for Tx_Start
// START  | start bit (Tx=0) for one bit time
// DATA   | shifting out latched word, LSB first
// PARITY | parity of latched word (inverted for odd parity)
// STOP   | line high for STOP_BITS bit times, then Tx_Done pulse
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_cfg_if.slave  bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [TW-1:0]        r_timer;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_next;
  logic [TW-1:0]        w_timer_next;
  logic [BW-1:0]        w_bit_idx_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_parity_next;
  logic                 w_tx_next;
  logic                 w_busy_next;
  logic                 w_done_next;
  logic                 w_bit_end;

  assign w_bit_end = (r_timer == BIT_LAST);

  // State and all output registers; outputs are driven only from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state and next-output logic; the bit timer runs 0..CLKS_PER_BIT-1
  // and is reloaded to 0 on every bit boundary regardless of state.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_tx_next      = r_tx;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;

    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
        if (bus.Tx_Start) begin
          w_shift_next   = bus.Data_to_send;
          w_parity_next  = (^bus.Data_to_send) ^ PAR_ODD;
          w_bit_idx_next = '0;
          w_state_next   = START;
          w_tx_next      = 1'b0;
          w_busy_next    = 1'b1;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_timer_next   = '0;
          w_bit_idx_next = '0;
          w_state_next   = DATA;
          w_tx_next      = r_shift[0];
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == DATA_LAST) begin
            w_bit_idx_next = '0;
            if (PAR_EN) begin
              w_state_next = PARITY;
              w_tx_next    = r_parity;
            end else begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_tx_next      = r_shift[1];
          end
        end
      end

      PARITY: begin
        if (w_bit_end) begin
          w_timer_next   = '0;
          w_bit_idx_next = '0;
          w_state_next   = STOP;
          w_tx_next      = 1'b1;
        end
      end

      STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_timer_next = '0;
          if (r_bit_idx == STOP_LAST) begin
            w_bit_idx_next = '0;
            w_state_next   = IDLE;
            w_busy_next    = 1'b0;
            w_done_next    = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end

      default: begin
        w_state_next   = IDLE;
        w_timer_next   = '0;
        w_bit_idx_next = '0;
        w_tx_next      = 1'b1;
        w_busy_next    = 1'b0;
      end
    endcase
  end

  assign bus.Tx      = r_tx;
  assign bus.Tx_Busy = r_busy;
  assign bus.Tx_Done = r_done;

endmodule
